// File: rtl/axi4_lite_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_slave_mem
//  Description : AXI4-Lite slave endpoint backed by a word-addressed register
//                memory. Independent write and read state machines share one
//                bus state type. Byte strobes are honoured on writes. Accesses
//                at or beyond MEM_DEPTH*4 bytes return SLVERR.
//  Ports       : ACLK, ARESET          - clock, synchronous active-high reset
//                AW*  (AWADDR/AWVALID/AWREADY)       - write address channel
//                W*   (WDATA/WSTRB/WVALID/WREADY)    - write data channel
//                B*   (BRESP/BVALID/BREADY)          - write response channel
//                AR*  (ARADDR/ARVALID/ARREADY)       - read address channel
//                R*   (RDATA/RRESP/RVALID/RREADY)    - read data channel
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_mem #(
    parameter int Addr_Width = 32,
    parameter int Data_Width = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [Addr_Width-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [Data_Width-1:0]   WDATA,
    input  logic [Data_Width/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [Addr_Width-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [Data_Width-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int                  c_IDX_W  = $clog2(MEM_DEPTH);
    localparam int                  c_STRB_W = Data_Width / 8;
    localparam logic [Addr_Width:0] c_LIMIT  = (Addr_Width + 1)'(MEM_DEPTH * 4);
    localparam logic [1:0]          c_OKAY   = 2'b00;
    localparam logic [1:0]          c_SLVERR = 2'b10;

    // Shared bus state encoding for both channel FSMs
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } bus_state_e;

    function automatic logic in_range(input logic [Addr_Width-1:0] a);
        return ({1'b0, a} < c_LIMIT);
    endfunction

    // ------------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------------
    logic [Data_Width-1:0] mem_q [MEM_DEPTH];

    bus_state_e            wstate_q, wstate_d;
    logic [Addr_Width-1:0] awaddr_q, awaddr_d;
    logic                  wr_ok_q,  wr_ok_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;

    bus_state_e            rstate_q, rstate_d;
    logic [Addr_Width-1:0] araddr_q, araddr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [Data_Width-1:0] rdata_q,   rdata_d;

    logic                  w_wr_commit;
    logic [c_IDX_W-1:0]    w_widx;
    logic [c_IDX_W-1:0]    w_ridx;

    assign w_widx = awaddr_q[2 +: c_IDX_W];
    assign w_ridx = araddr_q[2 +: c_IDX_W];

    // ------------------------------------------------------------------------
    // Write FSM: next state and registered-output decode
    // ------------------------------------------------------------------------
    always_comb begin
        wstate_d    = wstate_q;
        awaddr_d    = awaddr_q;
        wr_ok_d     = wr_ok_q;
        bresp_d     = bresp_q;
        w_wr_commit = 1'b0;
        case (wstate_q)
            IDLE: begin
                if (AWVALID && awready_q) begin
                    awaddr_d = AWADDR;
                    wstate_d = ADDR;
                end
            end
            ADDR: begin
                wr_ok_d  = in_range(awaddr_q);
                wstate_d = DATA;
            end
            DATA: begin
                if (WVALID && wready_q) begin
                    w_wr_commit = wr_ok_q;
                    bresp_d     = wr_ok_q ? c_OKAY : c_SLVERR;
                    wstate_d    = RESP;
                end
            end
            RESP: begin
                if (BREADY && bvalid_q) begin
                    wstate_d = IDLE;
                end
            end
            default: wstate_d = IDLE;
        endcase
        // Handshake outputs are registered from the next state so that they
        // are glitch-free and never depend combinationally on VALID inputs.
        awready_d = (wstate_d == IDLE);
        wready_d  = (wstate_d == DATA);
        bvalid_d  = (wstate_d == RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q  <= IDLE;
            awaddr_q  <= '0;
            wr_ok_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            wstate_q  <= wstate_d;
            awaddr_q  <= awaddr_d;
            wr_ok_q   <= wr_ok_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory array with per-byte-lane write enables
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_commit) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem_q[w_widx][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM: next state and registered-output decode
    // ------------------------------------------------------------------------
    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            IDLE: begin
                if (ARVALID && arready_q) begin
                    araddr_d = ARADDR;
                    rstate_d = ADDR;
                end
            end
            ADDR: begin
                // mem_q is sampled before any write landing on the same edge,
                // so a colliding write is not visible to this read.
                if (in_range(araddr_q)) begin
                    rdata_d = mem_q[w_ridx];
                    rresp_d = c_OKAY;
                end else begin
                    rdata_d = '0;
                    rresp_d = c_SLVERR;
                end
                rstate_d = DATA;
            end
            DATA: begin
                if (RREADY && rvalid_q) begin
                    rstate_d = IDLE;
                end
            end
            RESP:    rstate_d = IDLE;
            default: rstate_d = IDLE;
        endcase
        arready_d = (rstate_d == IDLE);
        rvalid_d  = (rstate_d == DATA);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_q  <= IDLE;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_slave_mem
//  Description : Self-checking bench for axi4_lite_slave_mem. A table of
//                directed write/read vectors with hand-computed results,
//                followed by backpressure, reset-abort and read/write
//                collision sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_mem;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_lite_slave_mem #(
        .Addr_Width (32),
        .Data_Width (32),
        .MEM_DEPTH  (256)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge with the write channel idle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input int hold, input string tag);
        int cyc;
        int wlat;
        int blat;
        AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = 1'b0;
        cyc = 0;
        while (!AWREADY && cyc < 20) begin
            @(negedge ACLK); cyc++;
        end
        check({tag, " awready"}, 32'(AWREADY), 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        cyc = 1; wlat = -1; blat = -1;
        while (blat < 0 && cyc < 20) begin
            if (WREADY && wlat < 0) wlat = cyc;
            if (BVALID) blat = cyc;
            else begin
                @(negedge ACLK); cyc++;
                if (wlat >= 0) WVALID = 1'b0;
            end
        end
        WVALID = 1'b0;
        check({tag, " wready latency"}, 32'(wlat), 32'd2);
        check({tag, " bvalid latency"}, 32'(blat), 32'd3);
        check({tag, " bresp"}, 32'(BRESP), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check({tag, " hold bvalid"}, 32'(BVALID), 32'd1);
            check({tag, " hold bresp"}, 32'(BRESP), 32'(exp_resp));
            check({tag, " hold awready"}, 32'(AWREADY), 32'd0);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check({tag, " bvalid cleared"}, 32'(BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold, input string tag);
        int cyc;
        int rlat;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
        cyc = 0;
        while (!ARREADY && cyc < 20) begin
            @(negedge ACLK); cyc++;
        end
        check({tag, " arready"}, 32'(ARREADY), 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        cyc = 1; rlat = -1;
        while (rlat < 0 && cyc < 20) begin
            if (RVALID) rlat = cyc;
            else begin
                @(negedge ACLK); cyc++;
            end
        end
        check({tag, " rvalid latency"}, 32'(rlat), 32'd2);
        check({tag, " rdata"}, RDATA, exp_data);
        check({tag, " rresp"}, 32'(RRESP), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check({tag, " hold rvalid"}, 32'(RVALID), 32'd1);
            check({tag, " hold rdata"}, RDATA, exp_data);
            check({tag, " hold arready"}, 32'(ARREADY), 32'd0);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check({tag, " rvalid cleared"}, 32'(RVALID), 32'd0);
    endtask

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    2'b00, 32'hDE22_BE44};
        vecs[4]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF,    2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0,    2'b10, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    2'b00, 32'hDE22_BE44};
        vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'b1000, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_03FF, 32'h0,         4'h0,    2'b00, 32'h1200_0000};
        vecs[10] = '{1'b1, 32'h0000_0013, 32'hAABB_CCDD, 4'b0010, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    2'b00, 32'hDE22_CC44};
        vecs[12] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0,    2'b00, 32'h0};
        vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    2'b10, 32'h0};
        vecs[15] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF,    2'b10, 32'h0};
        vecs[16] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0,    2'b00, 32'h1200_0000};

        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst awready", 32'(AWREADY), 32'd0);
        check("rst wready",  32'(WREADY),  32'd0);
        check("rst bvalid",  32'(BVALID),  32'd0);
        check("rst bresp",   32'(BRESP),   32'd0);
        check("rst arready", 32'(ARREADY), 32'd0);
        check("rst rvalid",  32'(RVALID),  32'd0);
        check("rst rresp",   32'(RRESP),   32'd0);
        check("rst rdata",   RDATA,        32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, 0,
                         $sformatf("v%0d wr", i));
            else
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 0,
                        $sformatf("v%0d rd", i));
        end

        // Backpressure on B and R channels
        do_write(32'h0000_0800, 32'h0000_0055, 4'hF, 2'b10, 5, "bp wr");
        do_read(32'h0000_0010, 32'hDE22_CC44, 2'b00, 5, "bp rd");

        // Reset while write FSM is in DATA
        AWADDR = 32'h0000_0010; AWVALID = 1'b1; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF;
        WVALID = 1'b0; BREADY = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        @(negedge ACLK);
        check("abort wready in data", 32'(WREADY), 32'd1);
        ARESET = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        check("abort awready", 32'(AWREADY), 32'd0);
        check("abort wready",  32'(WREADY),  32'd0);
        check("abort bvalid",  32'(BVALID),  32'd0);
        check("abort arready", 32'(ARREADY), 32'd0);
        check("abort rvalid",  32'(RVALID),  32'd0);
        check("abort rdata",   RDATA,        32'd0);
        ARESET = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("abort no bvalid", 32'(BVALID), 32'd0);
        end
        check("abort idle awready", 32'(AWREADY), 32'd1);
        BREADY = 1'b0;
        do_read(32'h0000_0010, 32'h0, 2'b00, 0, "abort rd 0x10");
        do_read(32'h0000_03FC, 32'h0, 2'b00, 0, "abort rd 0x3fc");

        // Write commit lands on the read's ADDR cycle for the same word
        AWADDR = 32'h0000_0008; AWVALID = 1'b1; WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF;
        WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        AWVALID = 1'b0;
        ARADDR = 32'h0000_0008; ARVALID = 1'b1; RREADY = 1'b0;
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("coll wready", 32'(WREADY), 32'd1);
        @(negedge ACLK);
        WVALID = 1'b0;
        check("coll rvalid", 32'(RVALID), 32'd1);
        check("coll rdata",  RDATA,        32'd0);
        check("coll rresp",  32'(RRESP),   32'd0);
        check("coll bvalid", 32'(BVALID), 32'd1);
        check("coll bresp",  32'(BRESP),   32'd0);
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        check("coll bvalid cleared", 32'(BVALID), 32'd0);
        check("coll rvalid cleared", 32'(RVALID), 32'd0);
        do_read(32'h0000_0008, 32'hA5A5_A5A5, 2'b00, 0, "coll reread");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
